// File: rtl/synth_dac_tx.sv
// I2S transmitter for the synth's mono audio word: same sample on both channels, with a
// per-frame soft mute/unmute gain ramp and coarse volume shift. Codec supplies DACLRCK.
module synth_dac_tx #(
    parameter int DATA_W   = 16,
    parameter int VOL_W    = 3,
    parameter int GAIN_MAX = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_daclrck,
    input  logic [DATA_W-1:0]           i_sample,
    input  logic                        i_en,
    input  logic                        i_mute,
    input  logic [VOL_W-1:0]            i_vol,
    output logic                        o_dacdat,
    output logic                        o_frame,
    output logic [$clog2(GAIN_MAX):0]   o_gain
);

    localparam int GAIN_W  = $clog2(GAIN_MAX) + 1;
    localparam int GAIN_SH = $clog2(GAIN_MAX);
    localparam int PROD_W  = DATA_W + GAIN_W + 1;
    localparam int CNT_W   = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StSend, StPad} state_e;

    state_e              state_q;
    logic                lrck_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   held_q;

    logic                left_edge;
    logic                right_edge;
    logic                load_l;
    logic                load_r;
    logic signed [PROD_W-1:0] samp_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod;
    logic [DATA_W-1:0]   word;
    logic [GAIN_W-1:0]   gain_next;

    assign left_edge  = lrck_q & ~i_daclrck;
    assign right_edge = ~lrck_q & i_daclrck;

    // A left edge starts a frame from any state; a right edge only replays an active frame.
    assign load_l = i_en & left_edge;
    assign load_r = i_en & right_edge & (state_q != StIdle);

    // Volume shift and gain scaling done at full product width so nothing overflows.
    assign samp_ext = $signed({{(PROD_W-DATA_W){i_sample[DATA_W-1]}}, i_sample}) >>> i_vol;
    assign gain_ext = $signed({{(PROD_W-GAIN_W){1'b0}}, o_gain});
    assign prod     = samp_ext * gain_ext;
    assign word     = DATA_W'(prod >>> GAIN_SH);

    always_comb begin
        gain_next = o_gain;
        if (i_mute) begin
            if (o_gain != '0) gain_next = o_gain - 1'b1;
        end else begin
            if (o_gain != GAIN_W'(GAIN_MAX)) gain_next = o_gain + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            lrck_q   <= 1'b0;
            cnt_q    <= '0;
            shift_q  <= '0;
            held_q   <= '0;
            o_dacdat <= 1'b0;
            o_frame  <= 1'b0;
            o_gain   <= '0;
        end else begin
            lrck_q  <= i_daclrck;
            o_frame <= 1'b0;
            if (load_l) begin
                // MSB goes out the cycle after edge detection (I2S one-bit delay).
                o_dacdat <= word[DATA_W-1];
                shift_q  <= {word[DATA_W-2:0], 1'b0};
                held_q   <= word;
                cnt_q    <= CNT_W'(DATA_W - 1);
                o_frame  <= 1'b1;
                o_gain   <= gain_next;
                state_q  <= StSend;
            end else if (load_r) begin
                o_dacdat <= held_q[DATA_W-1];
                shift_q  <= {held_q[DATA_W-2:0], 1'b0};
                cnt_q    <= CNT_W'(DATA_W - 1);
                state_q  <= StSend;
            end else if (state_q == StSend && cnt_q != '0) begin
                o_dacdat <= shift_q[DATA_W-1];
                shift_q  <= {shift_q[DATA_W-2:0], 1'b0};
                cnt_q    <= cnt_q - 1'b1;
            end else if (state_q == StSend) begin
                o_dacdat <= 1'b0;
                state_q  <= i_en ? StPad : StIdle;
            end else begin
                o_dacdat <= 1'b0;
                if (state_q == StPad && !i_en) state_q <= StIdle;
            end
        end
    end

endmodule

// File: tb/tb_synth_dac_tx.sv
// Randomized self-checking bench for synth_dac_tx: captures the serial stream per cycle and
// compares decoded words, frame strobes and gain against an arithmetic model of the ramp.
module tb_synth_dac_tx;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_daclrck;
    logic [15:0] i_sample;
    logic        i_en;
    logic        i_mute;
    logic [2:0]  i_vol;
    logic        o_dacdat;
    logic        o_frame;
    logic [4:0]  o_gain;

    int checks = 0;
    int errors = 0;
    int gain_m = 0;
    logic dat_q[$];
    logic frm_q[$];

    synth_dac_tx dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_daclrck (i_daclrck),
        .i_sample  (i_sample),
        .i_en      (i_en),
        .i_mute    (i_mute),
        .i_vol     (i_vol),
        .o_dacdat  (o_dacdat),
        .o_frame   (o_frame),
        .o_gain    (o_gain)
    );

    always #5 i_clk = ~i_clk;

    // floor(floor(s / 2^vol) * g / 16), truncated to 16 bits
    function automatic logic [15:0] exp_word(input logic [15:0] s, input int vol, input int g);
        int v;
        v = int'($signed(s));
        v = v >>> vol;
        v = v * g;
        v = v >>> 4;
        return v[15:0];
    endfunction

    function automatic logic [15:0] model_left(input logic [15:0] s);
        logic [15:0] w;
        w = exp_word(s, int'(i_vol), gain_m);
        if (i_mute) gain_m = (gain_m > 0) ? gain_m - 1 : 0;
        else        gain_m = (gain_m < 16) ? gain_m + 1 : 16;
        return w;
    endfunction

    task automatic run_half(input logic lvl, input int len, input int chg_at, input logic chg_val);
        @(posedge i_clk);
        #1 i_daclrck = lvl;
        for (int i = 0; i < len; i++) begin
            @(negedge i_clk);
            dat_q.push_back(o_dacdat);
            frm_q.push_back(o_frame);
            if (i == chg_at) i_en = chg_val;
        end
    endtask

    task automatic run_frame(input int ll, input int rl, input logic [15:0] sl,
                             input logic [15:0] sr, output logic [15:0] lw,
                             output logic [15:0] rw, output int nfrm, output int fpos,
                             output int pad1);
        int b;
        b = dat_q.size();
        i_sample = sl;
        run_half(1'b0, ll, -1, 1'b0);
        i_sample = sr;
        run_half(1'b1, rl, -1, 1'b0);
        lw = '0;
        rw = '0;
        for (int i = 1; i <= 16; i++) begin
            lw = {lw[14:0], dat_q[b+i]};
            rw = {rw[14:0], dat_q[b+ll+i]};
        end
        nfrm = 0;
        fpos = -1;
        pad1 = 0;
        for (int i = 0; i < ll + rl; i++) begin
            if (frm_q[b+i] === 1'b1) begin
                nfrm++;
                fpos = i;
            end
            if ((i >= 17 && i < ll) || i >= ll + 17)
                if (dat_q[b+i] !== 1'b0) pad1++;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_daclrck = 1'b1;
        i_en = 1'b0;
        i_mute = 1'b0;
        i_vol = '0;
        i_sample = '0;
        #1;
        checks++; if (o_dacdat !== 1'b0) begin errors++; $display("FAIL reset_dacdat: got %b expected 0", o_dacdat); end
        checks++; if (o_frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", o_frame); end
        checks++; if (o_gain !== 5'd0) begin errors++; $display("FAIL reset_gain: got %0d expected 0", o_gain); end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        gain_m = 0;
        checks++; if (o_gain !== 5'd0 || o_dacdat !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got gain %0d dat %b expected 0 0", o_gain, o_dacdat); end
    endtask

    task automatic test_ramp_up();
        logic [15:0] el, lw, rw;
        int nf, fp, p1;
        i_en = 1'b1;
        i_mute = 1'b0;
        i_vol = '0;
        for (int f = 1; f <= 18; f++) begin
            el = model_left(16'h4000);
            run_frame(32, 32, 16'h4000, 16'h4000, lw, rw, nf, fp, p1);
            checks++; if (lw !== el || rw !== el) begin errors++; $display("FAIL ramp_word f%0d: got %h/%h expected %h", f, lw, rw, el); end
            checks++; if (nf != 1 || fp != 1) begin errors++; $display("FAIL ramp_frame f%0d: got count %0d pos %0d expected 1 1", f, nf, fp); end
            checks++; if (p1 != 0) begin errors++; $display("FAIL ramp_pad f%0d: got %0d ones expected 0", f, p1); end
            checks++; if (o_gain !== 5'(gain_m)) begin errors++; $display("FAIL ramp_gain f%0d: got %0d expected %0d", f, o_gain, gain_m); end
            if (f == 1) begin
                checks++; if (lw !== 16'h0000) begin errors++; $display("FAIL ramp_f1: got %h expected 0000", lw); end
            end
            if (f == 2) begin
                checks++; if (lw !== 16'h0400) begin errors++; $display("FAIL ramp_f2: got %h expected 0400", lw); end
            end
            if (f >= 17) begin
                checks++; if (lw !== 16'h4000 || rw !== 16'h4000) begin errors++; $display("FAIL ramp_full f%0d: got %h/%h expected 4000", f, lw, rw); end
            end
        end
        checks++; if (o_gain !== 5'd16) begin errors++; $display("FAIL ramp_gain_max: got %0d expected 16", o_gain); end
    endtask

    task automatic test_vol_random();
        logic [15:0] el, lw, rw, s, sr;
        int nf, fp, p1, ll, rl;
        for (int k = 0; k < 12; k++) begin
            if (k == 0) begin
                s = 16'h8000;
                i_vol = 3'd2;
                ll = 32;
                rl = 32;
            end else begin
                s = 16'($urandom);
                i_vol = 3'($urandom_range(0, 7));
                ll = $urandom_range(17, 40);
                rl = $urandom_range(17, 40);
            end
            sr = 16'($urandom);
            el = model_left(s);
            run_frame(ll, rl, s, sr, lw, rw, nf, fp, p1);
            checks++; if (lw !== el || rw !== el) begin errors++; $display("FAIL vol_word k%0d: got %h/%h expected %h", k, lw, rw, el); end
            checks++; if (nf != 1 || fp != 1 || p1 != 0) begin errors++; $display("FAIL vol_frame k%0d: got count %0d pos %0d pad %0d expected 1 1 0", k, nf, fp, p1); end
            if (k == 0) begin
                checks++; if (lw !== 16'hE000 || rw !== 16'hE000) begin errors++; $display("FAIL vol_e000: got %h/%h expected e000", lw, rw); end
            end
        end
        i_vol = '0;
    endtask

    task automatic test_mute();
        logic [15:0] el, lw, rw, s;
        int nf, fp, p1;
        i_mute = 1'b1;
        for (int k = 0; k < 21; k++) begin
            if (k == 18) i_mute = 1'b0;
            s = 16'($urandom) | 16'h4000;
            el = model_left(s);
            run_frame(32, 32, s, s, lw, rw, nf, fp, p1);
            checks++; if (lw !== el || rw !== el) begin errors++; $display("FAIL mute_word k%0d: got %h/%h expected %h", k, lw, rw, el); end
            checks++; if (o_gain !== 5'(gain_m)) begin errors++; $display("FAIL mute_gain k%0d: got %0d expected %0d", k, o_gain, gain_m); end
            if (k >= 16 && k < 18) begin
                checks++; if (lw !== 16'h0 || rw !== 16'h0 || p1 != 0) begin errors++; $display("FAIL mute_silent k%0d: got %h/%h expected 0000", k, lw, rw); end
            end
        end
    endtask

    task automatic test_short();
        logic [15:0] s1, s2, w1, w2, lw, w2l, w2r;
        logic [7:0] r1;
        int b;
        s1 = 16'($urandom) | 16'h8080;
        s2 = 16'($urandom) | 16'h8001;
        w1 = model_left(s1);
        w2 = model_left(s2);
        b = dat_q.size();
        i_sample = s1;
        run_half(1'b0, 32, -1, 1'b0);
        run_half(1'b1, 8, -1, 1'b0);
        i_sample = s2;
        run_half(1'b0, 32, -1, 1'b0);
        run_half(1'b1, 32, -1, 1'b0);
        lw = '0;
        r1 = '0;
        w2l = '0;
        w2r = '0;
        for (int i = 1; i <= 16; i++) lw = {lw[14:0], dat_q[b+i]};
        for (int i = 0; i < 8; i++) r1 = {r1[6:0], dat_q[b+33+i]};
        for (int i = 0; i < 16; i++) begin
            w2l = {w2l[14:0], dat_q[b+41+i]};
            w2r = {w2r[14:0], dat_q[b+73+i]};
        end
        checks++; if (lw !== w1) begin errors++; $display("FAIL short_left: got %h expected %h", lw, w1); end
        checks++; if (r1 !== w1[15:8]) begin errors++; $display("FAIL short_trunc: got %h expected %h", r1, w1[15:8]); end
        checks++; if (w2l !== w2 || w2r !== w2) begin errors++; $display("FAIL short_next: got %h/%h expected %h", w2l, w2r, w2); end
        checks++; if (frm_q[b+41] !== 1'b1 || frm_q[b+40] !== 1'b0) begin errors++; $display("FAIL short_frame: got %b%b expected 01", frm_q[b+40], frm_q[b+41]); end
    endtask

    task automatic test_en_drop();
        logic [15:0] s, w, lw, rw, el;
        int b, ones, frs, nf, fp, p1;
        s = 16'($urandom) | 16'h8001;
        w = model_left(s);
        b = dat_q.size();
        i_sample = s;
        run_half(1'b0, 32, 6, 1'b0);
        run_half(1'b1, 32, -1, 1'b0);
        run_half(1'b0, 32, -1, 1'b0);
        run_half(1'b1, 32, 10, 1'b1);
        lw = '0;
        for (int i = 1; i <= 16; i++) lw = {lw[14:0], dat_q[b+i]};
        ones = 0;
        frs = 0;
        for (int i = 17; i < 128; i++) if (dat_q[b+i] !== 1'b0) ones++;
        for (int i = 2; i < 128; i++) if (frm_q[b+i] !== 1'b0) frs++;
        checks++; if (lw !== w) begin errors++; $display("FAIL endrop_word: got %h expected %h", lw, w); end
        checks++; if (ones != 0) begin errors++; $display("FAIL endrop_silent: got %0d ones expected 0", ones); end
        checks++; if (frs != 0) begin errors++; $display("FAIL endrop_noframe: got %0d strobes expected 0", frs); end
        checks++; if (o_gain !== 5'(gain_m)) begin errors++; $display("FAIL endrop_gain_held: got %0d expected %0d", o_gain, gain_m); end
        s = 16'($urandom);
        el = model_left(s);
        run_frame(32, 32, s, s, lw, rw, nf, fp, p1);
        checks++; if (lw !== el || rw !== el || nf != 1 || fp != 1) begin errors++; $display("FAIL enrise_word: got %h/%h frames %0d expected %h 1", lw, rw, nf, el); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] lw, rw, el;
        int nf, fp, p1;
        i_sample = 16'h7fff;
        @(posedge i_clk);
        #1 i_daclrck = 1'b0;
        repeat (4) @(posedge i_clk);
        #3 i_rst_n = 1'b0;
        #1;
        checks++; if (o_dacdat !== 1'b0) begin errors++; $display("FAIL rstmid_dacdat: got %b expected 0", o_dacdat); end
        checks++; if (o_gain !== 5'd0) begin errors++; $display("FAIL rstmid_gain: got %0d expected 0", o_gain); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1 i_daclrck = 1'b1;
        @(negedge i_clk);
        gain_m = 0;
        el = model_left(16'h4000);
        run_frame(32, 32, 16'h4000, 16'h4000, lw, rw, nf, fp, p1);
        checks++; if (lw !== 16'h0000 || rw !== 16'h0000 || lw !== el) begin errors++; $display("FAIL rstmid_frame1: got %h/%h expected 0000", lw, rw); end
        checks++; if (o_gain !== 5'd1 || nf != 1) begin errors++; $display("FAIL rstmid_gain1: got %0d frames %0d expected 1 1", o_gain, nf); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_vol_random();
        test_mute();
        test_short();
        test_en_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
